perforator: RTL and testbench
=============================

// Module: perforator
// PURPOSE
//  Puncturer on the encoder side of the convolutional FEC chain; the counterpart of the decoder-side depuncturer.
//  Takes rate-1/2 encoder pairs (X,Y) and deletes bits per the selected puncturing pattern.
//  Repacks the surviving bits into 2-bit output symbols (I/Q order) for the modulator.
//  Valid/ready on both sides; 4-bit bit-buffer absorbs odd-bit rates and backpressure.
// PARAMETERS
//  RATE_RST  0   rate code loaded into rate_q on reset (0=1/2,1=2/3,2=3/4,3=7/8)
//  CNT_W     16  width of statistics counters (PERF_CNT_EN only)
// PORTS
//  clk          in   1      clock
//  reset_n      in   1      reset, synchronous, active-low
//  i_code_rate  in   2      0=1/2, 1=2/3, 2=3/4, 3=7/8
//  i_vld        in   1      input pair valid
//  i_rdy        out  1      input ready; pair accepted when i_vld&&i_rdy
//  i_sync       in   1      qualifies accepted pair as first pair of frame
//  i_data       in   2      [1]=X, [0]=Y encoder outputs
//  o_vld        out  1      output symbol valid
//  o_rdy        in   1      downstream ready; symbol transferred when o_vld&&o_rdy
//  o_sync       out  1      with o_vld: symbol holds first kept bit of a sync pair
//  o_data       out  2      [1]=earlier bit, [0]=later bit
//  o_pair_cnt   out  CNT_W  output symbols transferred (PERF_CNT_EN)
//  o_drop_cnt   out  CNT_W  leftover bits discarded on sync (PERF_CNT_EN)
// BEHAVIOUR
//  Patterns (phase 0 first; X before Y within a pair), period P:
//   1/2 P=1: X=1       Y=1        -> X1Y1
//   2/3 P=2: X=10      Y=11       -> X1Y1Y2
//   3/4 P=3: X=101     Y=110      -> X1Y1Y2X3
//   7/8 P=7: X=1000101 Y=1111010  -> X1Y1Y2Y3Y4X5Y6X7
//  phase counter 0..P-1 advances per accepted pair; wraps to 0 after P-1.
//  rate_q <= i_code_rate on every accepted pair at phase 0; mid-pattern rate changes wait for next pattern start.
//  Accepted pair with i_sync=1: phase forced to 0, rate_q reloaded, pattern applied from phase 0.
//  Bit buffer: FIFO of up to 4 bits, count cnt 0..4.
//   k = kept bits of accepted pair (1 or 2); cnt_next = cnt + (acc?k:0) - (xfer?2:0).
//  i_rdy = (cnt<=2), from registered state only; no combinational path from o_rdy.
//  o_vld = (cnt>=2); o_data = two oldest bits. Both are registered state.
//  o_data/o_sync held stable while o_vld && !o_rdy.
//  Latency: pair accepted at edge N -> its bits visible on o_data after edge N, if ahead of them in FIFO.
//  Sync with cnt odd: single oldest-unpaired leftover bit discarded before new bits enter; even cnt flushes normally.
//  o_sync set on symbol whose o_data[1] is the first kept bit of a sync pair.
//  Simultaneous accept+transfer in same cycle: both applied; cnt per formula.
//  Reset (any time, incl. mid-pattern): cnt=0, phase=0, rate_q=RATE_RST, o_vld=0, o_data=0, o_sync=0; i_rdy=1 from first cycle after reset.
// CONFIGURATION
//  PERF_CNT_EN defined: o_pair_cnt +1 per transfer, o_drop_cnt +1 per discarded bit; wrap at 2^CNT_W; cleared by reset.
//  PERF_CNT_EN undefined: counters not built; o_pair_cnt/o_drop_cnt tied 0. Datapath identical either way.
// TESTING
//  T1 rate 1/2, o_rdy=1, pairs 10,01,11 back-to-back -> o_data 10,01,11 one cycle later, o_vld 3 cycles.
//  T2 rate 3/4, pairs 11,00,10 -> kept 1,1,0,1 -> o_data 11 then 01; phase back to 0.
//  T3 rate 7/8, 7 pairs of 10 -> kept 1,0,0,0,0,1,0,1 -> o_data 10,00,01,01.
//  T4 rate 1/2 stream, o_rdy=0 for 5 cycles -> i_rdy low once cnt=4, o_data held, no bit lost/duplicated after release.
//  T5 rate 2/3, pairs 11,11,11 then sync pair 01 -> symbols 11,11, leftover dropped, next 01 with o_sync=1; o_drop_cnt=1 (PERF_CNT_EN).
//  T6 reset_n low one cycle at phase 4 of 7/8 with cnt=3 -> o_vld=0, i_rdy=1 next cycle; restart yields T3 output exactly.

Source files
------------

// File: rtl/perforator.sv
// Convolutional-code puncturer: deletes bits of rate-1/2 (X,Y) pairs and repacks the survivors into 2-bit symbols.
// Optional statistics counters are built when PERF_CNT_EN is defined.
module perforator #(
  parameter int unsigned RATE_RST = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       i_code_rate,
  input  logic             i_vld,
  output logic             i_rdy,
  input  logic             i_sync,
  input  logic [1:0]       i_data,
  output logic             o_vld,
  input  logic             o_rdy,
  output logic             o_sync,
  output logic [1:0]       o_data,
  output logic [CNT_W-1:0] o_pair_cnt,
  output logic [CNT_W-1:0] o_drop_cnt
);

  // {keep X, keep Y} for a given rate code and pattern phase
  function automatic logic [1:0] keep_mask(input logic [1:0] r, input logic [2:0] p);
    logic [1:0] m;
    m = 2'b11;
    case (r)
      2'd0: m = 2'b11;
      2'd1: m = (p == 3'd0) ? 2'b11 : 2'b01;
      2'd2: begin
        case (p)
          3'd0:    m = 2'b11;
          3'd1:    m = 2'b01;
          default: m = 2'b10;
        endcase
      end
      default: begin
        case (p)
          3'd0:       m = 2'b11;
          3'd4, 3'd6: m = 2'b10;
          default:    m = 2'b01;
        endcase
      end
    endcase
    return m;
  endfunction

  function automatic logic [2:0] period_of(input logic [1:0] r);
    logic [2:0] n;
    case (r)
      2'd0:    n = 3'd1;
      2'd1:    n = 3'd2;
      2'd2:    n = 3'd3;
      default: n = 3'd7;
    endcase
    return n;
  endfunction

  // Bit 0 of buf_q/sf_q is the oldest bit in the FIFO
  logic [3:0] buf_q, buf_d;
  logic [3:0] sf_q, sf_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] phase_q, phase_d;
  logic [1:0] rate_q, rate_d;
  logic       vld_q, rdy_q;

  logic       acc, xfer, drop;
  logic [1:0] eff_rate;
  logic [2:0] eff_phase;
  logic [1:0] keep;
  logic [2:0] c;

  assign acc       = i_vld && rdy_q;
  assign xfer      = vld_q && o_rdy;
  assign eff_rate  = (i_sync || phase_q == 3'd0) ? i_code_rate : rate_q;
  assign eff_phase = i_sync ? 3'd0 : phase_q;
  assign keep      = keep_mask(eff_rate, eff_phase);
  // Transfer removes two bits, so cnt parity before and after it is the same
  assign drop      = acc && i_sync && cnt_q[0];

  always_comb begin
    buf_d   = buf_q;
    sf_d    = sf_q;
    c       = cnt_q;
    phase_d = phase_q;
    rate_d  = rate_q;
    if (xfer) begin
      buf_d = {2'b00, buf_q[3:2]};
      sf_d  = {2'b00, sf_q[3:2]};
      c     = cnt_q - 3'd2;
    end
    if (drop) begin
      c               = c - 3'd1;
      buf_d[c[1:0]]   = 1'b0;
      sf_d[c[1:0]]    = 1'b0;
    end
    if (acc) begin
      if (keep[1]) begin
        buf_d[c[1:0]] = i_data[1];
        sf_d[c[1:0]]  = i_sync;
        c             = c + 3'd1;
      end
      if (keep[0]) begin
        buf_d[c[1:0]] = i_data[0];
        sf_d[c[1:0]]  = i_sync && !keep[1];
        c             = c + 3'd1;
      end
      phase_d = (eff_phase == period_of(eff_rate) - 3'd1) ? 3'd0 : eff_phase + 3'd1;
      rate_d  = eff_rate;
    end
    cnt_d = c;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      buf_q   <= '0;
      sf_q    <= '0;
      cnt_q   <= '0;
      phase_q <= '0;
      rate_q  <= 2'(RATE_RST);
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      buf_q   <= buf_d;
      sf_q    <= sf_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      rate_q  <= rate_d;
      vld_q   <= (cnt_d >= 3'd2);
      rdy_q   <= (cnt_d <= 3'd2);
    end
  end

  assign i_rdy  = rdy_q;
  assign o_vld  = vld_q;
  assign o_data = {buf_q[0], buf_q[1]};
  assign o_sync = sf_q[0];

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] pair_cnt_q, drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pair_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (xfer) pair_cnt_q <= pair_cnt_q + 1'b1;
      if (drop) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign o_pair_cnt = pair_cnt_q;
  assign o_drop_cnt = drop_cnt_q;
`else
  assign o_pair_cnt = '0;
  assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_perforator.sv
// Directed-vector bench for the perforator puncturer.
module tb_perforator;
  logic        clk, reset_n;
  logic [1:0]  i_code_rate;
  logic        i_vld, i_rdy, i_sync;
  logic [1:0]  i_data;
  logic        o_vld, o_rdy, o_sync;
  logic [1:0]  o_data;
  logic [15:0] o_pair_cnt, o_drop_cnt;

  int npass = 0;
  int ntotal = 0;
  int vld_cyc = 0;
  logic [2:0] mon_q[$];

  perforator #(.RATE_RST(0), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .i_code_rate(i_code_rate),
    .i_vld(i_vld), .i_rdy(i_rdy), .i_sync(i_sync), .i_data(i_data),
    .o_vld(o_vld), .o_rdy(o_rdy), .o_sync(o_sync), .o_data(o_data),
    .o_pair_cnt(o_pair_cnt), .o_drop_cnt(o_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record {o_sync,o_data} of every symbol that will transfer on the next edge
  always @(negedge clk) begin
    if (reset_n && o_vld) vld_cyc++;
    if (reset_n && o_vld && o_rdy) mon_q.push_back({o_sync, o_data});
  end

  task automatic do_reset();
    reset_n = 1'b0;
    i_vld = 1'b0;
    i_sync = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    mon_q.delete();
    vld_cyc = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] d, input logic s);
    int n = 0;
    i_vld = 1'b1;
    i_data = d;
    i_sync = s;
    @(negedge clk);
    while (!i_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      ntotal++;
      $display("FAIL send_timeout: i_rdy=%0b want 1 within 50 cycles", i_rdy);
    end
    @(posedge clk);
    #1;
    i_vld = 1'b0;
    i_sync = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    ntotal++; if (o_vld !== 1'b0) $display("FAIL rst_o_vld: got %0b want 0", o_vld); else npass++;
    ntotal++; if (i_rdy !== 1'b1) $display("FAIL rst_i_rdy: got %0b want 1", i_rdy); else npass++;
    ntotal++; if (o_data !== 2'b00) $display("FAIL rst_o_data: got %0b want 00", o_data); else npass++;
    ntotal++; if (o_sync !== 1'b0) $display("FAIL rst_o_sync: got %0b want 0", o_sync); else npass++;
    ntotal++; if (o_pair_cnt !== 16'd0) $display("FAIL rst_pair_cnt: got %0d want 0", o_pair_cnt); else npass++;
    ntotal++; if (o_drop_cnt !== 16'd0) $display("FAIL rst_drop_cnt: got %0d want 0", o_drop_cnt); else npass++;
  endtask

  task automatic test_rate12();
    logic [2:0] exp [3];
    logic [2:0] got;
    exp = '{3'b010, 3'b001, 3'b011};
    do_reset();
    i_code_rate = 2'd0;
    o_rdy = 1'b1;
    send(2'b10, 1'b0);
    ntotal++; if (o_vld !== 1'b1) $display("FAIL r12_latency_vld: got %0b want 1", o_vld); else npass++;
    ntotal++; if (o_data !== 2'b10) $display("FAIL r12_latency_data: got %0b want 10", o_data); else npass++;
    send(2'b01, 1'b0);
    send(2'b11, 1'b0);
    idle(4);
    ntotal++; if (vld_cyc !== 3) $display("FAIL r12_vld_cycles: got %0d want 3", vld_cyc); else npass++;
    ntotal++; if (mon_q.size() !== 3) $display("FAIL r12_count: got %0d want 3", mon_q.size()); else npass++;
    for (int i = 0; i < 3; i++) begin
      got = (i < mon_q.size()) ? mon_q[i] : 3'bxxx;
      ntotal++; if (got !== exp[i]) $display("FAIL r12_sym%0d: got %b want %b", i, got, exp[i]); else npass++;
    end
  endtask

  task automatic test_rate34();
    logic [2:0] exp [3];
    logic [2:0] got;
    exp = '{3'b011, 3'b001, 3'b011};
    do_reset();
    i_code_rate = 2'd2;
    o_rdy = 1'b1;
    send(2'b11, 1'b0);
    send(2'b00, 1'b0);
    send(2'b10, 1'b0);
    // phase is back at 0: next pair keeps both bits, the one after keeps Y only
    send(2'b11, 1'b0);
    send(2'b01, 1'b0);
    idle(4);
    ntotal++; if (mon_q.size() !== 3) $display("FAIL r34_count: got %0d want 3", mon_q.size()); else npass++;
    for (int i = 0; i < 3; i++) begin
      got = (i < mon_q.size()) ? mon_q[i] : 3'bxxx;
      ntotal++; if (got !== exp[i]) $display("FAIL r34_sym%0d: got %b want %b", i, got, exp[i]); else npass++;
    end
  endtask

  task automatic run78(input string tag);
    logic [2:0] exp [4];
    logic [2:0] got;
    exp = '{3'b010, 3'b000, 3'b001, 3'b001};
    i_code_rate = 2'd3;
    o_rdy = 1'b1;
    mon_q.delete();
    for (int i = 0; i < 7; i++) send(2'b10, 1'b0);
    idle(4);
    ntotal++; if (mon_q.size() !== 4) $display("FAIL %s_count: got %0d want 4", tag, mon_q.size()); else npass++;
    for (int i = 0; i < 4; i++) begin
      got = (i < mon_q.size()) ? mon_q[i] : 3'bxxx;
      ntotal++; if (got !== exp[i]) $display("FAIL %s_sym%0d: got %b want %b", tag, i, got, exp[i]); else npass++;
    end
  endtask

  task automatic test_rate78();
    do_reset();
    run78("r78");
  endtask

  task automatic test_backpressure();
    logic [2:0] exp [4];
    logic [2:0] got;
    exp = '{3'b010, 3'b001, 3'b011, 3'b000};
    do_reset();
    i_code_rate = 2'd0;
    o_rdy = 1'b0;
    send(2'b10, 1'b0);
    send(2'b01, 1'b0);
    @(negedge clk);
    ntotal++; if (i_rdy !== 1'b0) $display("FAIL bp_i_rdy: got %0b want 0", i_rdy); else npass++;
    ntotal++; if (o_vld !== 1'b1) $display("FAIL bp_o_vld: got %0b want 1", o_vld); else npass++;
    ntotal++; if (o_data !== 2'b10) $display("FAIL bp_data: got %b want 10", o_data); else npass++;
    repeat (3) @(negedge clk);
    ntotal++; if (o_data !== 2'b10) $display("FAIL bp_held: got %b want 10", o_data); else npass++;
    @(posedge clk);
    #1 o_rdy = 1'b1;
    send(2'b11, 1'b0);
    send(2'b00, 1'b0);
    idle(5);
    ntotal++; if (mon_q.size() !== 4) $display("FAIL bp_count: got %0d want 4", mon_q.size()); else npass++;
    for (int i = 0; i < 4; i++) begin
      got = (i < mon_q.size()) ? mon_q[i] : 3'bxxx;
      ntotal++; if (got !== exp[i]) $display("FAIL bp_sym%0d: got %b want %b", i, got, exp[i]); else npass++;
    end
  endtask

  task automatic test_sync_drop();
    logic [2:0] exp [3];
    logic [2:0] got;
    logic [15:0] exp_pair, exp_drop;
    exp = '{3'b011, 3'b011, 3'b101};
`ifdef PERF_CNT_EN
    exp_pair = 16'd3;
    exp_drop = 16'd1;
`else
    exp_pair = 16'd0;
    exp_drop = 16'd0;
`endif
    do_reset();
    i_code_rate = 2'd1;
    o_rdy = 1'b1;
    send(2'b11, 1'b0);
    send(2'b11, 1'b0);
    send(2'b11, 1'b0);
    send(2'b01, 1'b1);
    idle(4);
    ntotal++; if (mon_q.size() !== 3) $display("FAIL sync_count: got %0d want 3", mon_q.size()); else npass++;
    for (int i = 0; i < 3; i++) begin
      got = (i < mon_q.size()) ? mon_q[i] : 3'bxxx;
      ntotal++; if (got !== exp[i]) $display("FAIL sync_sym%0d: got %b want %b", i, got, exp[i]); else npass++;
    end
    ntotal++; if (o_pair_cnt !== exp_pair) $display("FAIL sync_pair_cnt: got %0d want %0d", o_pair_cnt, exp_pair); else npass++;
    ntotal++; if (o_drop_cnt !== exp_drop) $display("FAIL sync_drop_cnt: got %0d want %0d", o_drop_cnt, exp_drop); else npass++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    i_code_rate = 2'd3;
    // Build phase 4 with three bits buffered
    o_rdy = 1'b0;
    send(2'b10, 1'b0);
    o_rdy = 1'b1;
    send(2'b10, 1'b0);
    send(2'b10, 1'b0);
    o_rdy = 1'b0;
    send(2'b10, 1'b0);
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    ntotal++; if (o_vld !== 1'b0) $display("FAIL mrst_o_vld: got %0b want 0", o_vld); else npass++;
    ntotal++; if (i_rdy !== 1'b1) $display("FAIL mrst_i_rdy: got %0b want 1", i_rdy); else npass++;
    run78("mrst");
  endtask

  initial begin
    reset_n = 1'b0;
    i_code_rate = 2'd0;
    i_vld = 1'b0;
    i_sync = 1'b0;
    i_data = 2'b00;
    o_rdy = 1'b1;
    test_reset();
    test_rate12();
    test_rate34();
    test_rate78();
    test_backpressure();
    test_sync_drop();
    test_mid_reset();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
